// File: rtl/fcvt_issue.sv
// fcvt_issue -- issue/retire controller for the FPU conversion units.
//
// Accepts conversion requests (ftoi / itof) over valid/ready, presents the
// operand to both units, tracks each in-flight op's tag through a per-unit
// shift pipe that matches the unit latency, and captures the unit result
// into an in-order result FIFO when the op leaves its pipe.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (issue = valid && ready)
//   req_op                0 = ftoi, 1 = itof
//   req_src, req_tag      operand and destination tag
//   ftoi_s/ftoi_d         operand to / result from the ftoi unit
//   itof_s/itof_d         operand to / result from the itof unit
//   res_valid/res_ready   result handshake to writeback (FIFO head)
//   res_data/tag/op       head entry contents
//   busy                  any op in flight or any result queued
module fcvt_issue #(
  parameter int TAG_W      = 5,
  parameter int FTOI_LAT   = 1,
  parameter int ITOF_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_src,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      ftoi_s,
  input  logic [31:0]      ftoi_d,
  output logic [31:0]      itof_s,
  input  logic [31:0]      itof_d,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_op,
  output logic             busy
);

  localparam int MAX_LAT = (FTOI_LAT > ITOF_LAT) ? FTOI_LAT : ITOF_LAT;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNTW    = PW + 1;
  // Wide enough for fifo count plus every pipe stage without overflow.
  localparam int CW      = $clog2(FIFO_DEPTH + FTOI_LAT + ITOF_LAT + 1) + 1;

  // Units sample every edge; only the issue cycle's operand matters.
  assign ftoi_s = req_src;
  assign itof_s = req_src;

  // ---------------- metadata pipes ----------------
  logic [FTOI_LAT-1:0] ftoi_v_q;
  logic [TAG_W-1:0]    ftoi_tag_q [FTOI_LAT];
  logic [ITOF_LAT-1:0] itof_v_q;
  logic [TAG_W-1:0]    itof_tag_q [ITOF_LAT];

  logic issue, issue_ftoi, issue_itof;
  assign issue      = req_valid && req_ready;
  assign issue_ftoi = issue && !req_op;
  assign issue_itof = issue &&  req_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftoi_v_q <= '0;
      itof_v_q <= '0;
      for (int i = 0; i < FTOI_LAT; i++) ftoi_tag_q[i] <= '0;
      for (int i = 0; i < ITOF_LAT; i++) itof_tag_q[i] <= '0;
    end else begin
      ftoi_v_q[0]   <= issue_ftoi;
      ftoi_tag_q[0] <= req_tag;
      for (int i = 1; i < FTOI_LAT; i++) begin
        ftoi_v_q[i]   <= ftoi_v_q[i-1];
        ftoi_tag_q[i] <= ftoi_tag_q[i-1];
      end
      itof_v_q[0]   <= issue_itof;
      itof_tag_q[0] <= req_tag;
      for (int i = 1; i < ITOF_LAT; i++) begin
        itof_v_q[i]   <= itof_v_q[i-1];
        itof_tag_q[i] <= itof_tag_q[i-1];
      end
    end
  end

  // ---------------- ordering / collision ----------------
  // An op sitting in stage s of a pipe of latency L pushes (L-1-s) cycles
  // from now. comp[k] marks a push k cycles ahead. A new op of latency L
  // pushes L cycles ahead, so any pending push at k >= L would either
  // collide with it or retire after it (out of order).
  logic [MAX_LAT-1:0] comp;
  always_comb begin
    comp = '0;
    for (int s = 0; s < FTOI_LAT; s++)
      if (ftoi_v_q[s]) comp[FTOI_LAT-1-s] = 1'b1;
    for (int s = 0; s < ITOF_LAT; s++)
      if (itof_v_q[s]) comp[ITOF_LAT-1-s] = 1'b1;
  end

  logic ftoi_order_ok, itof_order_ok, order_ok;
  assign ftoi_order_ok = ~|(comp >> FTOI_LAT);
  assign itof_order_ok = ~|(comp >> ITOF_LAT);
  assign order_ok      = req_op ? itof_order_ok : ftoi_order_ok;

  // ---------------- credits ----------------
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   inflight;
  always_comb begin
    inflight = '0;
    for (int s = 0; s < FTOI_LAT; s++) inflight = inflight + CW'(ftoi_v_q[s]);
    for (int s = 0; s < ITOF_LAT; s++) inflight = inflight + CW'(itof_v_q[s]);
  end

  // Registered count only: a pop in this same cycle does not free a credit.
  logic credit_ok;
  assign credit_ok = (CW'(cnt_q) + inflight) < CW'(FIFO_DEPTH);
  assign req_ready = credit_ok && order_ok;

  // ---------------- completion capture ----------------
  logic             ftoi_done, itof_done, push, pop;
  logic [31:0]      push_data;
  logic [TAG_W-1:0] push_tag;
  logic             push_op;

  assign ftoi_done = ftoi_v_q[FTOI_LAT-1];
  assign itof_done = itof_v_q[ITOF_LAT-1];
  assign push      = ftoi_done || itof_done;   // never both, see comp
  assign push_data = ftoi_done ? ftoi_d : itof_d;
  assign push_tag  = ftoi_done ? ftoi_tag_q[FTOI_LAT-1] : itof_tag_q[ITOF_LAT-1];
  assign push_op   = !ftoi_done;

  // ---------------- result FIFO ----------------
  logic [31:0]      data_mem_q [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem_q  [FIFO_DEPTH];
  logic             op_mem_q   [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;

  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
        op_mem_q[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= push_data;
        tag_mem_q[wr_ptr_q]  <= push_tag;
        op_mem_q[wr_ptr_q]   <= push_op;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign res_data = data_mem_q[rd_ptr_q];
  assign res_tag  = tag_mem_q[rd_ptr_q];
  assign res_op   = op_mem_q[rd_ptr_q];

  assign busy = (|ftoi_v_q) || (|itof_v_q) || res_valid;

endmodule

// File: tb/tb_fcvt_issue.sv
module tb_fcvt_issue;

  logic        clk, rst;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_src;
  logic [4:0]  req_tag;
  logic [31:0] ftoi_s, ftoi_d, itof_s, itof_d, itof_p;
  logic        res_valid, res_ready, res_op, busy;
  logic [31:0] res_data;
  logic [4:0]  res_tag;

  int errors = 0;
  int checks = 0;
  logic [37:0] sb [$];   // {data, tag, op}

  fcvt_issue #(.TAG_W(5), .FTOI_LAT(1), .ITOF_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_tag(req_tag),
    .ftoi_s(ftoi_s), .ftoi_d(ftoi_d), .itof_s(itof_s), .itof_d(itof_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_op(res_op), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conversion behaviour of the external units: exact values for the
  // directed operands, an arbitrary but distinct mapping elsewhere.
  function automatic logic [31:0] conv(input logic op, input logic [31:0] s);
    if (!op) begin
      case (s)
        32'h40490FDB: return 32'h00000003;
        32'hC0200000: return 32'hFFFFFFFD;
        default:      return s ^ 32'h5A5A5A5A;
      endcase
    end else begin
      case (s)
        32'd5:   return 32'h40A00000;
        32'd1:   return 32'h3F800000;
        default: return s ^ 32'hC3C3C3C3;
      endcase
    end
  endfunction

  // Unit models: ftoi 1 cycle, itof 2 cycles, sampling every edge.
  always @(posedge clk) begin
    ftoi_d <= conv(1'b0, ftoi_s);
    itof_p <= conv(1'b1, itof_s);
    itof_d <= itof_p;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard: every accepted result is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      chk("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        logic [37:0] e;
        e = sb.pop_front();
        chk("result", 64'({res_data, res_tag, res_op}), 64'(e));
        $display("pop  tag=%0d op=%0d data=%h", res_tag, res_op, res_data);
      end
    end
  end

  task automatic send(input logic op, input logic [31:0] src, input logic [4:0] tag,
                      output int waited);
    req_valid = 1'b1; req_op = op; req_src = src; req_tag = tag; waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({conv(op, src), tag, op});
        $display("issue tag=%0d op=%0d src=%h waited=%0d", tag, op, src, waited);
        break;
      end
      waited++;
      if (waited >= 40) begin
        chk("issue_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_src = $urandom; req_op = 1'($urandom); req_tag = 5'($urandom);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain_complete", 64'({sb.size() == 0, busy}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, acc;
    logic took;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_src = '0; req_tag = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_fields", 64'({res_data, res_tag, res_op}), 64'd0);
    @(posedge clk); #1;

    // ftoi pi -> 3, res_valid two cycles after issue
    send(1'b0, 32'h40490FDB, 5'd3, w);
    @(negedge clk); chk("ftoi_lat_c1", 64'(res_valid), 64'd0);
    @(negedge clk); chk("ftoi_lat_c2", 64'(res_valid), 64'd1);
    @(posedge clk); #1;

    // ftoi -2.5 -> -3
    send(1'b0, 32'hC0200000, 5'd7, w);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // itof 5 -> 5.0, res_valid three cycles after issue
    send(1'b1, 32'd5, 5'd1, w);
    @(negedge clk); chk("itof_lat_c1", 64'(res_valid), 64'd0);
    @(negedge clk); chk("itof_lat_c2", 64'(res_valid), 64'd0);
    @(negedge clk); chk("itof_lat_c3", 64'(res_valid), 64'd1);
    @(posedge clk); #1;
    drain();
    @(posedge clk); #1;

    // ftoi blocked the cycle after an itof issue
    send(1'b1, 32'd1, 5'd1, w);
    req_valid = 1'b1; req_op = 1'b0; req_src = 32'h40490FDB; req_tag = 5'd2;
    @(negedge clk); chk("ftoi_blocked_after_itof", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    send(1'b0, 32'h40490FDB, 5'd2, w);
    chk("ftoi_issue_next_cycle", 64'(w), 64'd0);
    drain();
    @(posedge clk); #1;

    // Credit limit: 6 ftoi with writeback stalled, then release
    res_ready = 1'b0; acc = 0;
    req_valid = 1'b1; req_op = 1'b0; req_src = $urandom; req_tag = 5'd10;
    for (int cyc = 0; cyc < 40 && acc < 6; cyc++) begin
      if (cyc == 8) begin
        chk("credit_accepted", 64'(acc), 64'd4);
        chk("credit_blocked", 64'(req_ready), 64'd0);
        chk("credit_busy", 64'(busy), 64'd1);
        res_ready = 1'b1;
      end
      @(negedge clk);
      if (cyc >= 8 && cyc < 12) chk("drain_back_to_back", 64'(res_valid), 64'd1);
      took = req_ready;
      if (took) begin
        sb.push_back({conv(1'b0, req_src), req_tag, 1'b0});
        $display("issue tag=%0d op=0 src=%h cycle=%0d", req_tag, req_src, cyc);
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin req_tag = 5'(10 + acc); req_src = $urandom; end
    end
    req_valid = 1'b0;
    chk("stream_all_issued", 64'(acc), 64'd6);
    drain();
    @(posedge clk); #1;

    // Simultaneous push and pop with three entries queued
    res_ready = 1'b0;
    send(1'b0, 32'h11111111, 5'd20, w);
    send(1'b0, 32'h22222222, 5'd21, w);
    send(1'b0, 32'h33333333, 5'd22, w);
    send(1'b0, 32'h44444444, 5'd23, w);
    res_ready = 1'b1;                 // pop tag 20 while tag 23 is pushed
    @(posedge clk); #1;
    res_ready = 1'b0; req_op = 1'b0;
    @(negedge clk);
    chk("pushpop_credit_free", 64'(req_ready), 64'd1);
    chk("pushpop_res_valid", 64'(res_valid), 64'd1);
    @(posedge clk); #1;
    send(1'b0, 32'h55555555, 5'd24, w);
    chk("pushpop_issue_wait", 64'(w), 64'd0);
    req_op = 1'b0;
    @(negedge clk);
    chk("pushpop_credit_full", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    drain();
    @(posedge clk); #1;

    // Asynchronous reset with ops in flight and a result queued
    res_ready = 1'b0;
    send(1'b0, 32'h66666666, 5'd8, w);
    send(1'b1, 32'h77777777, 5'd9, w);
    chk("pre_reset_res_valid", 64'(res_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_res_valid", 64'(res_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_res_fields", 64'({res_data, res_tag, res_op}), 64'd0);
    sb.delete();
    $display("reset asserted, in-flight ops discarded");
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_result_ignored", 64'({res_valid, busy}), 64'd0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcvt_issue.md
Name: fcvt_issue

Overview:
- Issue/retire controller for the FPU conversion units: ftoi (float->int, 1-cycle registered) and itof (int->float).
- Takes conversion requests from the FPU dispatch over valid/ready and drives the source operand into the selected unit.
- Tracks each in-flight op's tag and latency, and captures the unit's result on the completion cycle.
- Returns results strictly in issue order through a credit-protected output FIFO to writeback.

Parameters:
- TAG_W, 5, width of destination register tag.
- FTOI_LAT, 1, cycles from operand presented to ftoi_d valid; must be >=1.
- ITOF_LAT, 2, cycles from operand presented to itof_d valid; must be >=1.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid&&req_ready (issue).
- req_op  in  1  0=ftoi, 1=itof.
- req_src  in  32  operand (float bits for ftoi, signed int for itof).
- req_tag  in  TAG_W  destination tag.
- ftoi_s  out  32  operand to ftoi unit.
- ftoi_d  in  32  ftoi result.
- itof_s  out  32  operand to itof unit.
- itof_d  in  32  itof result.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  writeback accepts head.
- res_data  out  32  head result.
- res_tag  out  TAG_W  head tag.
- res_op  out  1  head op.
- busy  out  1  any op in flight or FIFO non-empty.

Behaviour:
- ftoi_s = itof_s = req_src, combinationally and unconditionally; units sample every edge, so only issue cycles matter.
- Per-unit metadata shift pipelines of depth LAT, each stage holding {valid, tag}. On issue, stage 0 loads {1, req_tag}; otherwise stage 0 loads valid=0. Stages advance every cycle; no stall inside the pipes.
- Completion: when the last stage of a pipe is valid, push {unit_d, tag, op} into the FIFO at that edge.
  - Issue handshake in cycle t -> unit_d sampled in cycle t+LAT -> res_valid in cycle t+LAT+1 at the earliest.
- Ordering/collision rule: completion vector comp[k] (k=1..max LAT) is set if some in-flight op completes k cycles from now. An op with latency L may issue only if comp[j]=0 for all j>=L.
  - Defaults: ftoi is blocked in the cycle after an itof issue.
  - This guarantees at most one push per cycle and in-order results.
- Credits: inflight = count of valid pipe stages. Issue allowed only if fifo_count + inflight < FIFO_DEPTH, using registered counts (a same-cycle pop is not credited). The FIFO therefore never overflows.
- req_ready = credit_ok && order_ok(req_op). It may depend on req_op; the requester holds op/src/tag stable while req_valid=1 and not accepted.
- FIFO: registered storage, res_* driven from the head entry.
  - Pop on res_valid&&res_ready.
  - Push and pop in the same cycle are both honoured; fifo_count is unchanged.
  - No bypass: a push into an empty FIFO becomes visible the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (async, any time including mid-operation): all pipe valids=0, FIFO pointers and count=0, res_valid=0, busy=0.
  - In-flight ops are discarded. Unit outputs arriving after reset are ignored because the pipe valids are clear.
  - req_ready=1 in the first cycle after reset deassertion.
  - res_data/res_tag/res_op reset to 0.
- busy = |pipe valids || fifo_count!=0.

Test Plan:
- ftoi req src=0x40490FDB tag=3 issued cycle 0, res_ready=1 -> res_valid cycle 2, res_data=0x00000003, res_tag=3, res_op=0.
- ftoi src=0xC0200000 (-2.5) tag=7 -> res_data=0xFFFFFFFD (-3, half away from zero), tag 7; itof src=5 tag=1 issued cycle 0 -> res_valid cycle 3, res_data=0x40A00000.
- itof (tag 1) accepted cycle 0, ftoi (tag 2) valid cycle 1 -> req_ready=0 in cycle 1; ftoi accepted cycle 2 -> results pop in order tag 1 then tag 2, never the same cycle.
- res_ready=0, stream 6 ftoi -> exactly 4 accepted, req_ready=0 thereafter, busy=1; raise res_ready -> tags pop in order, one per cycle, and remaining requests issue as credits free.
- Simultaneous push and pop with FIFO at 3 entries -> count stays 3, no tag lost or duplicated.
- Assert rst the cycle after an itof issue -> res_valid=0 and busy=0 immediately; stray itof_d ignored; req_ready=1 after release.
